// File: rtl/preadd_stage.sv
// preadd_stage: DSP48A1-style D/B pre-adder with optional stage-1 and B1 registers and a matching valid path
module preadd_stage #(
    parameter int    DREG      = 1,
    parameter int    B0REG     = 1,
    parameter int    OPMODEREG = 1,
    parameter int    B1REG     = 1,
    parameter string B_INPUT   = "DIRECT"
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        CED,
    input  logic        CEB,
    input  logic        CEOPMODE,
    input  logic [17:0] D,
    input  logic [17:0] B,
    input  logic [17:0] BCIN,
    input  logic [7:0]  OPMODE,
    input  logic        VALID_IN,
    output logic [17:0] B1_mux,
    output logic [17:0] BCOUT,
    output logic [7:0]  OPMODE_mux,
    output logic        VALID_OUT
);
    localparam bit CASCADE = (B_INPUT == "CASCADE");
    logic [17:0] d_q, b0_q, b1_q, b_sel, d1, b0, pre, s2;
    logic [7:0]  op_q;
    logic        v1_q, v2_q, v1;
    always_comb begin
        b_sel      = CASCADE ? BCIN : B;
        d1         = DREG != 0 ? d_q : D;
        b0         = B0REG != 0 ? b0_q : b_sel;
        OPMODE_mux = OPMODEREG != 0 ? op_q : OPMODE;
        pre        = OPMODE_mux[6] ? d1 - b0 : d1 + b0;
        s2         = OPMODE_mux[4] ? pre : b0;
        v1         = B0REG != 0 ? v1_q : VALID_IN;
        B1_mux     = B1REG != 0 ? b1_q : s2;
        BCOUT      = B1_mux;
        VALID_OUT  = B1REG != 0 ? v2_q : v1;
    end
    // CEB gates data and valid together so a stall keeps them aligned
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            d_q  <= '0;
            b0_q <= '0;
            op_q <= '0;
            b1_q <= '0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            if (CED) d_q <= D;
            if (CEOPMODE) op_q <= OPMODE;
            if (CEB) begin
                b0_q <= b_sel;
                b1_q <= s2;
                v1_q <= VALID_IN;
                v2_q <= v1;
            end
        end
    end
endmodule

// File: tb/tb_preadd_stage.sv
// tb_preadd_stage: directed vectors on five configurations, checked against a snapshot-history model
module tb_preadd_stage;
    logic        clk = 0, rstn = 0, ced = 1, ceb = 1, ceop = 1, valid_in = 1;
    logic [17:0] d = 18'h3FFFF, b = 18'h2AAAA, bcin = 18'h15555;
    logic [7:0]  opmode = 8'hFF;
    int checks = 0, failures = 0;
    bit started = 0;
    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] d, b, bc;
        logic [7:0]  op;
        logic        v;
    } snap_t;
    snap_t hist[$];
    snap_t zero_s = '{18'h0, 18'h0, 18'h0, 8'h0, 1'b0};

    logic [17:0] b1_a, bc_a, b1_c, bc_c, b1_01, bc_01, b1_10, bc_10, b1_00, bc_00;
    logic [7:0]  om_a, om_c, om_01, om_10, om_00;
    logic        vo_a, vo_c, vo_01, vo_10, vo_00;

    preadd_stage u_all (.CLK(clk), .RSTN(rstn), .CED(ced), .CEB(ceb), .CEOPMODE(ceop), .D(d), .B(b),
        .BCIN(bcin), .OPMODE(opmode), .VALID_IN(valid_in), .B1_mux(b1_a), .BCOUT(bc_a), .OPMODE_mux(om_a), .VALID_OUT(vo_a));
    preadd_stage #(.B_INPUT("CASCADE")) u_cas (.CLK(clk), .RSTN(rstn), .CED(ced), .CEB(ceb), .CEOPMODE(ceop), .D(d), .B(b),
        .BCIN(bcin), .OPMODE(opmode), .VALID_IN(valid_in), .B1_mux(b1_c), .BCOUT(bc_c), .OPMODE_mux(om_c), .VALID_OUT(vo_c));
    preadd_stage #(.DREG(0), .B0REG(0), .OPMODEREG(0), .B1REG(1)) u_01 (.CLK(clk), .RSTN(rstn), .CED(ced), .CEB(ceb),
        .CEOPMODE(ceop), .D(d), .B(b), .BCIN(bcin), .OPMODE(opmode), .VALID_IN(valid_in), .B1_mux(b1_01), .BCOUT(bc_01),
        .OPMODE_mux(om_01), .VALID_OUT(vo_01));
    preadd_stage #(.DREG(1), .B0REG(1), .OPMODEREG(1), .B1REG(0)) u_10 (.CLK(clk), .RSTN(rstn), .CED(ced), .CEB(ceb),
        .CEOPMODE(ceop), .D(d), .B(b), .BCIN(bcin), .OPMODE(opmode), .VALID_IN(valid_in), .B1_mux(b1_10), .BCOUT(bc_10),
        .OPMODE_mux(om_10), .VALID_OUT(vo_10));
    preadd_stage #(.DREG(0), .B0REG(0), .OPMODEREG(0), .B1REG(0)) u_00 (.CLK(clk), .RSTN(rstn), .CED(ced), .CEB(ceb),
        .CEOPMODE(ceop), .D(d), .B(b), .BCIN(bcin), .OPMODE(opmode), .VALID_IN(valid_in), .B1_mux(b1_00), .BCOUT(bc_00),
        .OPMODE_mux(om_00), .VALID_OUT(vo_00));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    function automatic snap_t live();
        return '{d, b, bcin, opmode, valid_in};
    endfunction

    // Result a slice produces from one set of captured operands
    function automatic logic [17:0] result(snap_t s, bit cas);
        logic [17:0] bs = cas ? s.bc : s.b;
        return s.op[4] ? (s.op[6] ? s.d - bs : s.d + bs) : bs;
    endfunction

    // Reset leaves the pipeline full of zero operands; each enabled edge captures one input set
    always @(posedge clk) begin
        if (!rstn) begin
            hist = {zero_s, zero_s};
            started = 1;
        end else if (ceb) begin
            hist.push_back(live());
            if (hist.size() > 4) void'(hist.pop_front());
        end
    end

    task automatic cmp(input string nm, input int lat, input bit opreg, input bit cas, input logic [17:0] b1,
                       input logic [17:0] bc, input logic [7:0] om, input logic vo);
        snap_t s = lat == 0 ? live() : hist[hist.size() - lat];
        check({nm, ".b1"}, 32'(b1), 32'(result(s, cas)));
        check({nm, ".bcout"}, 32'(bc), 32'(result(s, cas)));
        check({nm, ".opmode"}, 32'(om), 32'(opreg ? hist[hist.size() - 1].op : opmode));
        check({nm, ".valid"}, 32'(vo), 32'(s.v));
    endtask

    always @(negedge clk) begin
        if (started) begin
            cmp("all", 2, 1, 0, b1_a, bc_a, om_a, vo_a);
            cmp("cas", 2, 1, 1, b1_c, bc_c, om_c, vo_c);
            cmp("r01", 1, 0, 0, b1_01, bc_01, om_01, vo_01);
            cmp("r10", 1, 1, 0, b1_10, bc_10, om_10, vo_10);
            cmp("r00", 0, 0, 0, b1_00, bc_00, om_00, vo_00);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ce(input logic v);
        ced = v;
        ceb = v;
        ceop = v;
    endtask

    initial begin
        cyc();
        cyc();
        check("rst_b1", 32'(b1_a), 0);
        check("rst_bcout", 32'(bc_a), 0);
        check("rst_opmode", 32'(om_a), 0);
        check("rst_valid", 32'(vo_a), 0);
        rstn = 1; d = 5; b = 3; opmode = 8'h10; valid_in = 1;
        cyc();
        check("lat1_valid", 32'(vo_a), 0);
        check("lat1_r10", 32'(b1_10), 8);
        d = 0; b = 1; opmode = 8'h50;
        cyc();
        check("add_5p3", 32'(b1_a), 8);
        check("add_valid", 32'(vo_a), 1);
        d = 18'h3FFFF; b = 1; opmode = 8'h10;
        cyc();
        check("sub_wrap", 32'(b1_a), 32'h3FFFF);
        d = 7; b = 18'h0FFF; bcin = 18'h1234; opmode = 8'h00;
        cyc();
        check("add_wrap", 32'(b1_a), 0);
        cyc();
        check("bypass_direct", 32'(b1_a), 32'h0FFF);
        check("bypass_cascade", 32'(b1_c), 32'h1234);
        check("cascade_bcout", 32'(bc_c), 32'h1234);
        b = 1;
        cyc();
        b = 2;
        cyc();
        check("stream_1", 32'(b1_a), 1);
        set_ce(0); b = 3;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("stall_hold", 32'(b1_a), 1);
            check("stall_valid", 32'(vo_a), 1);
        end
        set_ce(1);
        cyc();
        check("resume_2", 32'(b1_a), 2);
        b = 0; valid_in = 0;
        cyc();
        check("resume_3", 32'(b1_a), 3);
        check("resume_3_valid", 32'(vo_a), 1);
        cyc();
        check("drain_valid", 32'(vo_a), 0);
        rstn = 0; b = 18'h2AAAA; valid_in = 1;
        cyc();
        check("rstpri_b1", 32'(b1_a), 0);
        check("rstpri_valid", 32'(vo_a), 0);
        check("rstpri_r10", 32'(b1_10), 0);
        rstn = 1; d = 7; b = 2; opmode = 8'h10;
        #1;
        check("sweep_r00", 32'(b1_00), 9);
        check("sweep_r00_valid", 32'(vo_00), 1);
        cyc();
        check("sweep_r01", 32'(b1_01), 9);
        check("sweep_r10", 32'(b1_10), 9);
        check("sweep_all_early", 32'(b1_a), 0);
        cyc();
        check("sweep_all", 32'(b1_a), 9);
        check("sweep_all_valid", 32'(vo_a), 1);
        rstn = 0;
        cyc();
        check("midrst_valid", 32'(vo_a), 0);
        check("midrst_b1", 32'(b1_a), 0);
        rstn = 1;
        cyc();
        check("post_rst_1", 32'(vo_a), 0);
        cyc();
        check("post_rst_2", 32'(vo_a), 1);
        check("post_rst_b1", 32'(b1_a), 9);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
